conv_sequencer: RTL and testbench

- Control FSM that drives the 8-bit signed MAC convolution datapath (clken / s_convout / en_sat / en_mult_r) over a full 2-D valid convolution: stride 1, KxK kernel, NUM_OC output channels.
- Generates read addresses for the signal, weight and bias memories and writes the saturated 8-bit result to the output buffer.
- Sits between the layer-level top controller (start/done) and one datapath instance plus its memories.

---
 rtl/conv_pkg.sv | 32 +++
 rtl/conv_addr_gen.sv | 96 +++++++++
 rtl/conv_sequencer.sv | 161 ++++++++++++++++
 tb/tb_conv_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types, geometry helpers and default latencies for conv_sequencer
//
// Contents:
//   state_t         sequencer FSM states
//   DEF_READ_LAT    default signal/weight memory read latency (cycles)
//   DEF_MAC_LAT     default last-clken to accumulator-valid latency (cycles)
//   out_dim()       valid-convolution output size for one axis
//   tap_count()     taps per window for a KxK kernel

package conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_SAT   = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int DEF_READ_LAT = 1;
    localparam int DEF_MAC_LAT  = 1;

    function automatic int out_dim(input int img, input int k);
        return img - k + 1;
    endfunction

    function automatic int tap_count(input int k);
        return k * k;
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// rtl/conv_addr_gen.sv - nested oc/row/col/kr/kc counters and memory address generation
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   clear          return every counter to 0
//   tap_step       advance the kc/kr tap counters (kc inner, wraps into kr)
//   win_step       advance col/row/oc window counters and the output address
//   sig_addr       (row+kr)*IMG_W + col + kc
//   wgt_addr       oc*K*K + kr*K + kc
//   bias_addr      oc
//   out_addr       linear output index 0 .. NUM_OC*OH*OW-1
//   first_tap      current tap is kr=kc=0
//   last_tap       current tap is kr=kc=K-1
//   last_window    current window is the final one of the layer

module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4,
    parameter int K      = 3,
    parameter int NUM_OC = 1,
    parameter int AW     = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          tap_step,
    input  logic          win_step,
    output logic [AW-1:0] sig_addr,
    output logic [AW-1:0] wgt_addr,
    output logic [AW-1:0] bias_addr,
    output logic [AW-1:0] out_addr,
    output logic          first_tap,
    output logic          last_tap,
    output logic          last_window
);

    localparam int OW = out_dim(IMG_W, K);
    localparam int OH = out_dim(IMG_H, K);

    logic [AW-1:0] kc;
    logic [AW-1:0] kr;
    logic [AW-1:0] col;
    logic [AW-1:0] row;
    logic [AW-1:0] oc;
    logic [AW-1:0] out_cnt;

    assign first_tap   = (kr == '0) && (kc == '0);
    assign last_tap    = (kr == AW'(K - 1)) && (kc == AW'(K - 1));
    assign last_window = (col == AW'(OW - 1)) && (row == AW'(OH - 1)) &&
                         (oc == AW'(NUM_OC - 1));

    // Tap counters wrap back to 0 after the last tap so the next window
    // starts at kr=kc=0; the window counters move only on win_step so that
    // bias_addr stays on the current channel through drain/saturate/write.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            kc      <= '0;
            kr      <= '0;
            col     <= '0;
            row     <= '0;
            oc      <= '0;
            out_cnt <= '0;
        end else begin
            if (tap_step) begin
                if (kc == AW'(K - 1)) begin
                    kc <= '0;
                    kr <= (kr == AW'(K - 1)) ? '0 : kr + 1'b1;
                end else begin
                    kc <= kc + 1'b1;
                end
            end
            if (win_step) begin
                out_cnt <= last_window ? '0 : out_cnt + 1'b1;
                if (col == AW'(OW - 1)) begin
                    col <= '0;
                    if (row == AW'(OH - 1)) begin
                        row <= '0;
                        oc  <= (oc == AW'(NUM_OC - 1)) ? '0 : oc + 1'b1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign sig_addr  = (row + kr) * AW'(IMG_W) + col + kc;
    assign wgt_addr  = oc * AW'(tap_count(K)) + kr * AW'(K) + kc;
    assign bias_addr = oc;
    assign out_addr  = out_cnt;

endmodule

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - control FSM driving the signed 8-bit MAC datapath over a 2-D valid convolution
//
// Optional build macro: CONV_RELU_EN (negative results written as 0).
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start          one-cycle pulse, begins a layer (ignored while busy)
//   busy           high from the cycle after an accepted start through DONE
//   done           one-cycle pulse at layer completion
//   sig_addr       signal memory read address
//   wgt_addr       weight memory read address
//   bias_addr      bias memory read address (= output channel)
//   mac_clken      datapath clken
//   mac_sload      datapath s_convout, first tap of a window
//   mac_en_sat     datapath en_sat
//   mac_en_mult_r  datapath en_mult_r
//   conv_in        signed datapath convout
//   out_we         output buffer write enable
//   out_addr       output buffer write address
//   out_data       output buffer write data

module conv_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_W    = 4,
    parameter int IMG_H    = 4,
    parameter int K        = 3,
    parameter int NUM_OC   = 1,
    parameter int READ_LAT = DEF_READ_LAT,
    parameter int MAC_LAT  = DEF_MAC_LAT,
    parameter int AW       = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     sig_addr,
    output logic [AW-1:0]     wgt_addr,
    output logic [AW-1:0]     bias_addr,
    output logic              mac_clken,
    output logic              mac_sload,
    output logic              mac_en_sat,
    output logic              mac_en_mult_r,
    input  logic signed [7:0] conv_in,
    output logic              out_we,
    output logic [AW-1:0]     out_addr,
    output logic [7:0]        out_data
);

    localparam int DRAIN_LEN = READ_LAT + MAC_LAT;
    localparam int DW        = $clog2(DRAIN_LEN + 1);

    state_t state;
    state_t state_next;

    logic [DW-1:0]       drain_cnt;
    logic [READ_LAT-1:0] vld_sr;
    logic [READ_LAT-1:0] first_sr;

    logic tap_valid;
    logic tap_step;
    logic win_step;
    logic clear;
    logic first_tap;
    logic last_tap;
    logic last_window;
    logic [7:0] wr_data;

    conv_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .K      (K),
        .NUM_OC (NUM_OC),
        .AW     (AW)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .tap_step    (tap_step),
        .win_step    (win_step),
        .sig_addr    (sig_addr),
        .wgt_addr    (wgt_addr),
        .bias_addr   (bias_addr),
        .out_addr    (out_addr),
        .first_tap   (first_tap),
        .last_tap    (last_tap),
        .last_window (last_window)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counts cycles spent in DRAIN; held at 0 in every other state.
    always_ff @(posedge clk) begin
        if (reset || (state != ST_DRAIN)) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + 1'b1;
        end
    end

    // Tap-valid / first-tap flags travel alongside the memory read so that
    // clken and sload line up with the data they qualify.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_sr   <= '0;
            first_sr <= '0;
        end else begin
            vld_sr[0]   <= tap_valid;
            first_sr[0] <= tap_valid && first_tap;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_sr[i]   <= vld_sr[i-1];
                first_sr[i] <= first_sr[i-1];
            end
        end
    end

    assign mac_clken = vld_sr[READ_LAT-1];
    assign mac_sload = first_sr[READ_LAT-1];

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_RUN;
            ST_RUN:   if (last_tap) state_next = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == DW'(DRAIN_LEN - 1)) state_next = ST_SAT;
            ST_SAT:   state_next = ST_WRITE;
            ST_WRITE: state_next = last_window ? ST_DONE : ST_RUN;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
`ifdef CONV_RELU_EN
        wr_data = conv_in[7] ? 8'd0 : conv_in;
`else
        wr_data = conv_in;
`endif
    end

    always_comb begin
        tap_valid     = (state == ST_RUN);
        tap_step      = (state == ST_RUN);
        win_step      = (state == ST_WRITE);
        clear         = (state == ST_IDLE);
        busy          = (state != ST_IDLE);
        done          = (state == ST_DONE);
        mac_en_sat    = (state == ST_SAT) || (state == ST_WRITE);
        mac_en_mult_r = (state != ST_IDLE);
        out_we        = (state == ST_WRITE);
        out_data      = (state == ST_WRITE) ? wr_data : 8'd0;
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// tb/tb_conv_sequencer.sv - randomized self-checking bench for conv_sequencer with a behavioural datapath

module tb_conv_sequencer;

    localparam int IMG_W   = 4;
    localparam int IMG_H   = 4;
    localparam int K       = 3;
    localparam int NOC     = 2;
    localparam int AW      = 12;
    localparam int OW      = IMG_W - K + 1;
    localparam int OH      = IMG_H - K + 1;
    localparam int TAPS    = K * K;
    localparam int WIN     = NOC * OH * OW;
    localparam int PER_OUT = TAPS + 1 + 1 + 2;
    localparam int DEPTH   = 1 << AW;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic [AW-1:0]     sig_addr;
    logic [AW-1:0]     wgt_addr;
    logic [AW-1:0]     bias_addr;
    logic              mac_clken;
    logic              mac_sload;
    logic              mac_en_sat;
    logic              mac_en_mult_r;
    logic signed [7:0] conv_in;
    logic              out_we;
    logic [AW-1:0]     out_addr;
    logic [7:0]        out_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    conv_sequencer #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .K        (K),
        .NUM_OC   (NOC),
        .READ_LAT (1),
        .MAC_LAT  (1),
        .AW       (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .sig_addr      (sig_addr),
        .wgt_addr      (wgt_addr),
        .bias_addr     (bias_addr),
        .mac_clken     (mac_clken),
        .mac_sload     (mac_sload),
        .mac_en_sat    (mac_en_sat),
        .mac_en_mult_r (mac_en_mult_r),
        .conv_in       (conv_in),
        .out_we        (out_we),
        .out_addr      (out_addr),
        .out_data      (out_data)
    );

    logic signed [7:0] sig_mem  [0:DEPTH-1];
    logic signed [7:0] wgt_mem  [0:DEPTH-1];
    logic signed [7:0] bias_mem [0:DEPTH-1];

    // Datapath stand-in: registered memories (one-cycle read), MAC that
    // loads on sload, and a >>>9 + bias saturating output stage.
    logic signed [7:0] sig_q;
    logic signed [7:0] wgt_q;
    int                acc = 0;
    int                dp_v;

    function automatic logic signed [7:0] sat8(input int v);
        if (v > 127) return 8'sd127;
        if (v < -128) return -8'sd128;
        return 8'(v);
    endfunction

    always @(posedge clk) begin
        sig_q <= sig_mem[int'(sig_addr)];
        wgt_q <= wgt_mem[int'(wgt_addr)];
        if (mac_clken) begin
            acc <= mac_sload ? int'(sig_q) * int'(wgt_q)
                             : acc + int'(sig_q) * int'(wgt_q);
        end
    end

    always_comb begin
        dp_v    = (acc >>> 9) + int'(bias_mem[int'(bias_addr)]);
        conv_in = sat8(dp_v);
    end

    function automatic int ref_out(input int oc, input int row, input int col);
        int s;
        int v;
        s = 0;
        for (int kr = 0; kr < K; kr++) begin
            for (int kc = 0; kc < K; kc++) begin
                s += int'(sig_mem[(row + kr) * IMG_W + col + kc]) *
                     int'(wgt_mem[oc * TAPS + kr * K + kc]);
            end
        end
        v = int'(sat8((s >>> 9) + int'(bias_mem[oc])));
`ifdef CONV_RELU_EN
        if (v < 0) v = 0;
`endif
        return v;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string pfx);
        check({pfx, "_busy"}, int'(busy), 0);
        check({pfx, "_done"}, int'(done), 0);
        check({pfx, "_clken"}, int'(mac_clken), 0);
        check({pfx, "_sload"}, int'(mac_sload), 0);
        check({pfx, "_en_sat"}, int'(mac_en_sat), 0);
        check({pfx, "_en_mult_r"}, int'(mac_en_mult_r), 0);
        check({pfx, "_out_we"}, int'(out_we), 0);
        check({pfx, "_out_data"}, int'(out_data), 0);
        check({pfx, "_sig_addr"}, int'(sig_addr), 0);
        check({pfx, "_wgt_addr"}, int'(wgt_addr), 0);
        check({pfx, "_bias_addr"}, int'(bias_addr), 0);
        check({pfx, "_out_addr"}, int'(out_addr), 0);
    endtask

    task automatic fill(input int s, input int w, input int b, input bit rnd);
        for (int i = 0; i < DEPTH; i++) begin
            sig_mem[i]  = rnd ? 8'($urandom_range(0, 255)) : 8'(s);
            wgt_mem[i]  = rnd ? 8'($urandom_range(0, 255)) : 8'(w);
            bias_mem[i] = rnd ? 8'(int'($urandom_range(0, 80)) - 40) : 8'(b);
        end
    endtask

    // Runs one layer and checks every cycle against the per-window timeline:
    // phases 0..TAPS-1 issue taps, clken trails by one cycle, then two drain
    // cycles, SAT, WRITE; done follows the last WRITE.
    task automatic run_layer(input bit extra_start);
        int exp_q[$];
        int widx;
        int done_cnt;
        int done_cyc;
        int w, ph, oc, row, col, kr, kc;
        bit finished;
        widx = 0;
        done_cnt = 0;
        done_cyc = -1;
        finished = 1'b0;
        for (int o = 0; o < NOC; o++)
            for (int r = 0; r < OH; r++)
                for (int c = 0; c < OW; c++)
                    exp_q.push_back(ref_out(o, r, c));

        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= PER_OUT * WIN + 40 && !finished; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check("busy_after_done", int'(busy), 0);
                check("done_width", int'(done), 0);
                finished = 1'b1;
            end else begin
                w  = (cyc - 1) / PER_OUT;
                ph = (cyc - 1) % PER_OUT;
                if (w < WIN) begin
                    oc  = w / (OH * OW);
                    row = (w % (OH * OW)) / OW;
                    col = w % OW;
                    check("busy", int'(busy), 1);
                    check("en_mult_r", int'(mac_en_mult_r), 1);
                    check("done_early", int'(done), 0);
                    if (ph < TAPS) begin
                        kr = ph / K;
                        kc = ph % K;
                        check("sig_addr", int'(sig_addr), (row + kr) * IMG_W + col + kc);
                        check("wgt_addr", int'(wgt_addr), oc * TAPS + kr * K + kc);
                    end
                    check("bias_addr", int'(bias_addr), oc);
                    check("clken", int'(mac_clken), int'(ph >= 1 && ph <= TAPS));
                    check("sload", int'(mac_sload), int'(ph == 1));
                    check("en_sat", int'(mac_en_sat), int'(ph >= TAPS + 2));
                    check("out_we", int'(out_we), int'(ph == TAPS + 3));
                end
                if (out_we) begin
                    if (exp_q.size() == 0) begin
                        check("extra_write", 1, 0);
                    end else begin
                        check("out_addr", int'(out_addr), widx);
                        check("out_data", int'($signed(out_data)), exp_q.pop_front());
                        widx++;
                    end
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check("busy_in_done", int'(busy), 1);
                    if (extra_start) start = 1'b1;
                end
                if (extra_start && cyc == 20) start = 1'b1;
            end
        end
        start = 1'b0;
        check("done_count", done_cnt, 1);
        check("latency", done_cyc + 1, 1 + WIN * PER_OUT + 1);
        check("write_count", widx, WIN);
    endtask

    task automatic reset_mid_run();
        int dcount;
        dcount = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_reset", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle("mid_reset");
        for (int i = 0; i < 2 * PER_OUT * WIN; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("no_done_after_reset", dcount, 0);
        check("idle_after_reset", int'(busy), 0);
    endtask

    initial begin
        fill(0, 0, 0, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle("idle");

        fill(64, 64, 0, 1'b0);
        run_layer(1'b0);

        fill(100, 100, 0, 1'b0);
        run_layer(1'b0);

        fill(-100, 100, 0, 1'b0);
        run_layer(1'b0);

        reset_mid_run();

        fill(0, 0, 0, 1'b1);
        run_layer(1'b1);

        for (int t = 0; t < 3; t++) begin
            fill(0, 0, 0, 1'b1);
            run_layer(1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
